// File: rtl/axi4lite_regbank_pkg.sv
// Shared types, register-map indices and helpers for the AXI4-Lite register bank.
package axi4lite_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    localparam int IDX_IRQ_EN   = 0;
    localparam int IDX_IRQ_STAT = 1;
    localparam int IDX_RW_FIRST = 2;

    // Read-only status registers occupy the top num_ro indices of the map.
    function automatic logic is_ro(input logic [31:0] idx,
                                   input int unsigned num_regs,
                                   input int unsigned num_ro);
        return idx >= (num_regs - num_ro);
    endfunction

endpackage

// File: rtl/axi4lite_wr_hold.sv
// One-entry holding register for an AXI valid/ready channel: accepts a beat
// when empty and keeps it until the consumer pops it.
module axi4lite_wr_hold #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_held,
    output logic [W-1:0] o_data,
    input  logic         i_pop
);

    logic         r_held;
    logic [W-1:0] r_data;
    logic         w_push;

    assign o_ready = i_en & ~r_held;
    assign w_push  = i_valid & o_ready;
    assign o_held  = r_held;
    assign o_data  = r_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (w_push) begin
            r_held <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_held <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite register bank: RW control registers, W1C interrupt status with
// enable mask, read-only status inputs and SLVERR on writes to read-only slots.
module axi4lite_regbank_slave
    import axi4lite_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_RO           = 4
) (
    input  logic                                              S_AXI_ACLK,
    input  logic                                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_AWADDR,
    input  logic [2:0]                                        S_AXI_AWPROT,
    input  logic                                              S_AXI_AWVALID,
    output logic                                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                   S_AXI_WSTRB,
    input  logic                                              S_AXI_WVALID,
    output logic                                              S_AXI_WREADY,
    output logic [1:0]                                        S_AXI_BRESP,
    output logic                                              S_AXI_BVALID,
    input  logic                                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_ARADDR,
    input  logic [2:0]                                        S_AXI_ARPROT,
    input  logic                                              S_AXI_ARVALID,
    output logic                                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_RDATA,
    output logic [1:0]                                        S_AXI_RRESP,
    output logic                                              S_AXI_RVALID,
    input  logic                                              S_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                     irq_set_i,
    input  logic [C_NUM_RO*C_S_AXI_DATA_WIDTH-1:0]            status_i,
    output logic [(C_NUM_REGS-C_NUM_RO-2)*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic                                              irq_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NW = C_NUM_REGS - C_NUM_RO;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("axi4lite_regbank_slave: only a 32-bit data bus is supported");
    end
    if ((C_NUM_REGS & (C_NUM_REGS - 1)) != 0 || C_NUM_REGS < C_NUM_RO + 3) begin : g_bad_regs
        $error("axi4lite_regbank_slave: C_NUM_REGS must be a power of two >= C_NUM_RO+3");
    end
    if (C_S_AXI_ADDR_WIDTH != $clog2(C_NUM_REGS) + 2) begin : g_bad_aw
        $error("axi4lite_regbank_slave: C_S_AXI_ADDR_WIDTH must equal $clog2(C_NUM_REGS)+2");
    end

    logic              r_en;
    logic [DW-1:0]     r_regs [NW];
    logic              r_bvalid;
    resp_t             r_bresp;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic              r_irq;

    logic              w_aw_held;
    logic [IW-1:0]     w_aw_idx;
    logic              w_w_held;
    logic [DW+NB-1:0]  w_w_payload;
    logic [DW-1:0]     w_wdata;
    logic [NB-1:0]     w_wstrb;
    logic [DW-1:0]     w_mask;
    logic              w_commit;
    logic              w_wr_ro;
    logic [DW-1:0]     w_irq_clr;
    logic [DW-1:0]     w_irq_stat_next;
    logic [IW-1:0]     w_ar_idx;
    logic              w_ar_hs;
    logic [DW-1:0]     w_rd_data;
    logic              w_unused;

    // Handshakes stay closed until the first clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    axi4lite_wr_hold #(.W(IW)) u_aw_hold (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_en    (r_en),
        .i_valid (S_AXI_AWVALID),
        .o_ready (S_AXI_AWREADY),
        .i_data  (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .o_held  (w_aw_held),
        .o_data  (w_aw_idx),
        .i_pop   (w_commit)
    );

    axi4lite_wr_hold #(.W(DW + NB)) u_w_hold (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_en    (r_en),
        .i_valid (S_AXI_WVALID),
        .o_ready (S_AXI_WREADY),
        .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .o_held  (w_w_held),
        .o_data  (w_w_payload),
        .i_pop   (w_commit)
    );

    assign w_wdata  = w_w_payload[DW-1:0];
    assign w_wstrb  = w_w_payload[DW+NB-1:DW];
    assign w_commit = w_aw_held & w_w_held & (~r_bvalid | S_AXI_BREADY);
    assign w_wr_ro  = is_ro(32'(w_aw_idx), C_NUM_REGS, C_NUM_RO);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < NB; b++) begin
            w_mask[b*8 +: 8] = {8{w_wstrb[b]}};
        end
    end

    // Hardware set is OR-ed in after the software clear, so a simultaneous set wins.
    always_comb begin
        w_irq_clr = '0;
        if (w_commit && w_aw_idx == IW'(IDX_IRQ_STAT)) begin
            w_irq_clr = w_wdata & w_mask;
        end
        w_irq_stat_next = (r_regs[IDX_IRQ_STAT] & ~w_irq_clr) | irq_set_i;
    end

    // NOTE: the register array is built from flops and must read as zero after reset, so it is reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NW; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (i == IDX_IRQ_STAT) begin
                    r_regs[i] <= w_irq_stat_next;
                end else if (w_commit && w_aw_idx == IW'(i)) begin
                    r_regs[i] <= (r_regs[i] & ~w_mask) | (w_wdata & w_mask);
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ro ? SLVERR : OKAY;
        end else if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;

    assign w_ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign S_AXI_ARREADY = r_en & (~r_rvalid | S_AXI_RREADY);
    assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NW; i++) begin
            if (w_ar_idx == IW'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
        for (int k = 0; k < C_NUM_RO; k++) begin
            if (w_ar_idx == IW'(NW + k)) begin
                w_rd_data = status_i[k*DW +: DW];
            end
        end
    end

    // Read data comes from the pre-edge registers, so a same-cycle write is not visible yet.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = OKAY;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_regs[IDX_IRQ_STAT] & r_regs[IDX_IRQ_EN]);
        end
    end

    assign irq_o = r_irq;

    for (genvar g = 0; g < NW - IDX_RW_FIRST; g++) begin : g_ctrl
        assign ctrl_o[g*DW +: DW] = r_regs[IDX_RW_FIRST + g];
    end

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Directed scoreboard bench for axi4lite_regbank_slave: expected responses are
// queued when a transaction is issued and compared when the DUT answers.
module tb_axi4lite_regbank_slave;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int RO = 4;
    localparam int NW = N - RO;
    localparam int AW = 6;

    logic            clk;
    logic            S_AXI_ARESET;
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [3:0]      S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    logic [DW-1:0]   irq_set_i;
    logic [RO*DW-1:0] status_i;
    logic [(NW-2)*DW-1:0] ctrl_o;
    logic            irq_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_regs [NW];
    logic [1:0]    exp_b [$];
    logic [DW-1:0] exp_r [$];

    axi4lite_regbank_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .irq_set_i     (irq_set_i),
        .status_i      (status_i),
        .ctrl_o        (ctrl_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_regs[i] = '0;
    endtask

    // Reference behaviour of one committed write; queues the expected BRESP.
    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strb[b]}};
        if (idx >= NW) begin
            exp_b.push_back(2'b10);
        end else begin
            exp_b.push_back(2'b00);
            if (idx == 1) m_regs[1] = m_regs[1] & ~(data & mask);
            else          m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
        end
    endtask

    function automatic logic [31:0] model_read(input int idx);
        if (idx < NW) return m_regs[idx];
        return status_i[(idx - NW)*DW +: DW];
    endfunction

    task automatic send_aw(input int idx);
        int cyc = 0;
        S_AXI_AWADDR  = AW'(idx * 4);
        S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        while (!S_AXI_AWREADY && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("aw_handshake", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int cyc = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        @(negedge clk);
        while (!S_AXI_WREADY && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("w_handshake", 32'(S_AXI_WREADY), 32'd1);
        @(posedge clk);
        #1;
        S_AXI_WVALID = 1'b0;
    endtask

    // Consumes exactly one B beat (BREADY must be high) and scores it.
    task automatic wait_b();
        int cyc = 0;
        logic [1:0] exp;
        @(negedge clk);
        while (!S_AXI_BVALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("bvalid_seen", 32'(S_AXI_BVALID), 32'd1);
        check("b_scoreboard_nonempty", 32'(exp_b.size() != 0), 32'd1);
        exp = (exp_b.size() != 0) ? exp_b.pop_front() : 2'b11;
        check("bresp", 32'(S_AXI_BRESP), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        fork
            send_aw(idx);
            send_w(data, strb);
        join
        model_write(idx, data, strb);
        wait_b();
    endtask

    task automatic axi_read_exp(input int idx, input logic [31:0] exp);
        int cyc = 0;
        logic [31:0] e;
        S_AXI_ARADDR  = AW'(idx * 4);
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        while (!S_AXI_ARREADY && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ar_handshake", 32'(S_AXI_ARREADY), 32'd1);
        exp_r.push_back(exp);
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!S_AXI_RVALID && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rvalid_seen", 32'(S_AXI_RVALID), 32'd1);
        e = exp_r.pop_front();
        check($sformatf("rdata_idx%0d", idx), S_AXI_RDATA, e);
        check("rresp", 32'(S_AXI_RRESP), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input int idx);
        axi_read_exp(idx, model_read(idx));
    endtask

    task automatic check_ctrl();
        for (int k = 0; k < NW - 2; k++) begin
            check($sformatf("ctrl_o_%0d", k + 2), ctrl_o[k*DW +: DW], m_regs[k + 2]);
        end
    endtask

    initial begin
        S_AXI_ARESET  = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        irq_set_i     = '0;
        status_i      = '0;
        model_reset();

        // Reset held for 20 cycles: every handshake output low.
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("reset_handshakes",
              32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        check("reset_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA[27:0]}, 32'd0);
        check("reset_irq", 32'(irq_o), 32'd0);
        @(posedge clk);
        #1;
        S_AXI_ARESET = 1'b0;
        for (int i = 0; i < N; i++) axi_read_exp(i, 32'd0);

        status_i = {32'hDEAD_0003, 32'hBEEF_0002, 32'hCAFE_0001, 32'hF00D_0000};

        // AW and W together to idx 2..5, then exact read-back.
        for (int i = 0; i < 4; i++) axi_write(2 + i, 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read_exp(2 + i, 32'(i + 1));

        // W ahead of AW while BREADY is low: second write must wait for B.
        S_AXI_BREADY = 1'b0;
        fork
            send_aw(6);
            send_w(32'hA5A5_0006, 4'hF);
        join
        model_write(6, 32'hA5A5_0006, 4'hF);
        send_w(32'h1234_5678, 4'hF);
        repeat (3) @(negedge clk);
        check("w_held_wready", 32'(S_AXI_WREADY), 32'd0);
        @(posedge clk);
        #1;
        send_aw(7);
        @(negedge clk);
        check("both_held_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
        check("b_stalled", 32'(S_AXI_BVALID), 32'd1);
        axi_read_exp(7, 32'd0);
        model_write(7, 32'h1234_5678, 4'hF);
        S_AXI_BREADY = 1'b1;
        wait_b();
        wait_b();
        axi_read(6);
        axi_read(7);

        // Byte strobes; an all-zero strobe changes nothing and still answers OKAY.
        axi_write(2, 32'h0000_0000, 4'hF);
        axi_write(2, 32'hFFFF_FFFF, 4'b0101);
        axi_read_exp(2, 32'h00FF_00FF);
        axi_write(3, 32'hFFFF_FFFF, 4'b0000);
        axi_read_exp(3, 32'h0000_0002);
        check_ctrl();

        // Writes to read-only slots: SLVERR, reads reflect status_i.
        axi_write(N - 1, 32'h1111_2222, 4'hF);
        axi_read_exp(N - 1, 32'hDEAD_0003);
        axi_read(NW);

        // Interrupt: enable bit 0, pulse it, then clear with and without a colliding set.
        axi_write(0, 32'h1, 4'hF);
        irq_set_i = 32'h1;
        @(posedge clk);
        #1;
        irq_set_i = '0;
        m_regs[1] = m_regs[1] | 32'h1;
        @(negedge clk);
        check("irq_after_1cyc", 32'(irq_o), 32'd0);
        @(negedge clk);
        check("irq_after_2cyc", 32'(irq_o), 32'd1);

        fork
            send_aw(1);
            send_w(32'h1, 4'hF);
        join
        irq_set_i = 32'h1;
        @(posedge clk);
        #1;
        irq_set_i = '0;
        model_write(1, 32'h1, 4'hF);
        m_regs[1] = m_regs[1] | 32'h1;
        wait_b();
        @(negedge clk);
        check("irq_set_wins", 32'(irq_o), 32'd1);
        axi_read(1);

        fork
            send_aw(1);
            send_w(32'h1, 4'hF);
        join
        model_write(1, 32'h1, 4'hF);
        @(negedge clk);
        check("irq_before_clear", 32'(irq_o), 32'd1);
        wait_b();
        check("irq_clear_1cyc", 32'(irq_o), 32'd0);

        irq_set_i = 32'h2;
        @(posedge clk);
        #1;
        irq_set_i = '0;
        m_regs[1] = m_regs[1] | 32'h2;
        repeat (3) @(negedge clk);
        check("irq_masked", 32'(irq_o), 32'd0);
        axi_read(1);

        // Reset with an address beat in flight: stale AW must not pair with a later W.
        send_aw(2);
        S_AXI_ARESET = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        S_AXI_ARESET = 1'b0;
        model_reset();
        send_w(32'h0000_0077, 4'hF);
        repeat (3) @(negedge clk);
        check("no_spurious_b", 32'(S_AXI_BVALID), 32'd0);
        @(posedge clk);
        #1;
        send_aw(2);
        model_write(2, 32'h0000_0077, 4'hF);
        wait_b();
        axi_read(2);
        axi_read(6);
        check_ctrl();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
